// File: rtl/memory_arbiter_nport.sv
// N-requester burst arbiter in front of the SDRAM controller; fixed priority by default,
// round-robin when MEM_ARB_ROUND_ROBIN_EN is defined. Grant is registered 1 cycle after request
// and held until i_MEM_Last; controller handshakes pass straight through to the granted port only.
module memory_arbiter_nport #(
    parameter int NUM_PORTS     = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 22
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Reset,
    input  logic [NUM_PORTS-1:0]                 i_Req_Valid,
    input  logic [NUM_PORTS-1:0]                 i_Req_Read_Write_n,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]   i_Req_Address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      i_Req_Data,
    output logic [NUM_PORTS-1:0]                 o_Req_Valid,
    output logic [NUM_PORTS-1:0]                 o_Req_Data_Read,
    output logic [NUM_PORTS-1:0]                 o_Req_Last,
    output logic [DATA_WIDTH-1:0]                o_Req_Data,
    output logic [NUM_PORTS-1:0]                 o_Grant,
    output logic                                 o_MEM_Valid,
    output logic [ADDRESS_WIDTH-1:0]             o_MEM_Address,
    output logic                                 o_MEM_Read_Write_n,
    output logic [DATA_WIDTH-1:0]                o_MEM_Data,
    input  logic                                 i_MEM_Data_Read,
    input  logic [DATA_WIDTH-1:0]                i_MEM_Data,
    input  logic                                 i_MEM_Data_Valid,
    input  logic                                 i_MEM_Last
);

    // A single-port build still needs a 1-bit index.
    localparam int GRANT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [NUM_PORTS-1:0]   winner;
    logic                   found;
    logic [GRANT_W-1:0]     grant_idx;
    logic                   busy;

    assign busy = (state_q == BUSY);

    always_comb begin
        grant_idx = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (grant_q[j]) grant_idx = GRANT_W'(j);
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [GRANT_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (busy && i_MEM_Last) begin
            ptr_d = (grant_idx == GRANT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end
`endif

    // Search ports at or above the pointer first, then wrap to the lowest requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && i_Req_Valid[j] && (j >= int'(ptr_q))) begin
                winner[j] = 1'b1;
                found     = 1'b1;
            end
        end
`endif
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && i_Req_Valid[j]) begin
                winner[j] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (|i_Req_Valid) begin
                    state_d = BUSY;
                    grant_d = winner;
                end
            end
            BUSY: begin
                if (i_MEM_Last) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // grant_q is all-zero in IDLE, so the defaults double as the idle values.
    always_comb begin
        o_MEM_Address      = '0;
        o_MEM_Data         = '0;
        o_MEM_Read_Write_n = 1'b1;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (grant_q[j]) begin
                o_MEM_Address      = i_Req_Address[j*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                o_MEM_Data         = i_Req_Data[j*DATA_WIDTH +: DATA_WIDTH];
                o_MEM_Read_Write_n = i_Req_Read_Write_n[j];
            end
        end
    end

    assign o_Grant         = grant_q;
    assign o_MEM_Valid     = busy;
    assign o_Req_Valid     = grant_q & {NUM_PORTS{i_MEM_Data_Valid}};
    assign o_Req_Data_Read = grant_q & {NUM_PORTS{i_MEM_Data_Read}};
    assign o_Req_Last      = grant_q & {NUM_PORTS{i_MEM_Last}};
    assign o_Req_Data      = busy ? i_MEM_Data : '0;

endmodule
